imem_loader: RTL and testbench

//  Byte-stream program loader: the write side of the instruction ROM/RAM.
//  - Accepts a framed byte stream (typically from the UART RX) and assembles little-endian 32-bit words.
//  - Writes each word into instruction memory through a single write port.
//  - Holds the CPU in reset (cpu_hold) for the whole load; releases it only after the checksum verifies.

---
 rtl/imem_loader.sv | 179 +++++++++++++++++
 tb/tb_imem_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (magic, length, little-endian
// data words, checksum), writes each word to instruction memory, and holds
// the CPU in reset until the checksum verifies.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start, stream not accepted
// MAGIC | sliding 4-byte window until the frame start word is seen
// LEN   | collecting the 32-bit little-endian word count N
// DATA  | assembling words; one write strobe after each 4th byte
// CSUM  | one checksum byte; mod-256 total must be zero
// DONE  | image verified, CPU released
// ERROR | oversize image or bad checksum, CPU stays held
`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 10
`endif

module imem_loader #(
  parameter int          ADDR_WIDTH = `ROM_ADDR_WIDTH,
  parameter logic [31:0] MAGIC      = 32'hB007_55AA
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [31:0] MEM_SIZE = 32'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAGIC = 3'd1,
    S_LEN   = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t                state_q, state_d;
  // Only the three most recent bytes are kept; the incoming byte completes the word.
  logic [23:0]           win_q, win_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [31:0]           len_q, len_d;
  // One bit wider than the address so a full-size image is counted without wrap.
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [7:0]            sum_q, sum_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                  accept;
  logic [31:0]           shifted;
  logic [7:0]            sum_next;
  logic                  last_word;

  assign accept    = in_valid & in_ready;
  assign shifted   = {in_data, win_q};
  assign sum_next  = sum_q + in_data;
  assign last_word = ((32'(idx_q) + 32'd1) == len_q);

  // State and datapath registers; reset drops any write not yet strobed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      bcnt_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      bcnt_q  <= bcnt_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state logic: byte framing, word assembly and checksum decision.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    bcnt_d  = bcnt_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;

    if (we_q) begin
      idx_d = idx_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_MAGIC;
          win_d   = '0;
          bcnt_d  = '0;
          len_d   = '0;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      S_MAGIC: begin
        if (accept) begin
          win_d = shifted[31:8];
          if (shifted == MAGIC) begin
            state_d = S_LEN;
            bcnt_d  = '0;
          end
        end
      end
      S_LEN: begin
        if (accept) begin
          win_d  = shifted[31:8];
          sum_d  = sum_next;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            len_d = shifted;
            if (shifted > MEM_SIZE) begin
              state_d = S_ERROR;
            end else if (shifted == 32'd0) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          win_d  = shifted[31:8];
          sum_d  = sum_next;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = shifted;
            if (last_word) begin
              state_d = S_CSUM;
            end
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          sum_d   = sum_next;
          state_d = (sum_next == 8'h00) ? S_DONE : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_MAGIC) || (state_q == S_LEN) ||
                     (state_q == S_DATA)  || (state_q == S_CSUM);
  assign in_ready  = busy;
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);
  assign cpu_hold  = busy | error;
  assign mem_we    = we_q;
  assign mem_addr  = idx_q[ADDR_WIDTH-1:0];
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a small memory (8 words).
module tb_imem_loader;

  localparam int AW = 3;
  localparam int MSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold, busy, done, error;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t wlog[$];
  logic prev_we = 1'b0;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_t e;
      e.addr = 32'(mem_addr);
      e.data = mem_wdata;
      wlog.push_back(e);
      n_checks++;
      if (prev_we) begin
        n_fail++;
        $display("FAIL we_back_to_back: mem_we high two cycles running at t=%0t", $time);
      end
    end
    prev_we = mem_we;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Presents a byte (caller is at a negedge); returns at the negedge after transfer.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
    int t = 0;
    while (!in_ready && t < 100) begin
      in_valid = 1'b0;
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: in_ready=0 expected 1 for byte 0x%02h", b);
      return;
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = with_start;
    @(negedge clk);
    start = 1'b0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_magic(input int gm);
    logic [31:0] m;
    m = 32'hB007_55AA;
    for (int b = 0; b < 4; b++)
      send_byte(m[8*b +: 8], gm > 0 ? int'($urandom_range(gm, 0)) : 0, 1'b0);
  endtask

  typedef struct {
    string             name;
    int                nw;
    logic [7:0][31:0]  w;
    bit                garbage;
    int                gap_max;
    bit                bad_csum;
    bit                start_poke;
    bit                exp_done;
  } vec_t;

  vec_t tv[7];

  task automatic run_load(input int i);
    logic [7:0]  sum;
    logic [7:0]  cs;
    logic [31:0] n;
    int          g;
    wlog.delete();
    pulse_start();
    chk({tv[i].name, "_armed_err"},  32'(error), 32'd0);
    chk({tv[i].name, "_armed_hold"}, 32'(cpu_hold), 32'd1);
    chk({tv[i].name, "_armed_busy"}, 32'(busy), 32'd1);
    g = tv[i].gap_max;
    if (tv[i].garbage) begin
      send_byte(8'hAA, 0, 1'b0);
      send_byte(8'h55, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
    end
    send_magic(g);
    chk({tv[i].name, "_no_we_before_len"}, 32'(wlog.size()), 32'd0);
    sum = 8'h00;
    n = 32'(tv[i].nw);
    for (int b = 0; b < 4; b++) begin
      sum += n[8*b +: 8];
      send_byte(n[8*b +: 8], g > 0 ? int'($urandom_range(g, 0)) : 0, 1'b0);
    end
    for (int k = 0; k < tv[i].nw; k++) begin
      for (int b = 0; b < 4; b++) begin
        sum += tv[i].w[k][8*b +: 8];
        send_byte(tv[i].w[k][8*b +: 8], g > 0 ? int'($urandom_range(g, 0)) : 0,
                  tv[i].start_poke && k == 0 && b == 0);
      end
    end
    cs = 8'h00 - sum + (tv[i].bad_csum ? 8'h01 : 8'h00);
    send_byte(cs, 0, tv[i].start_poke);
    in_valid = 1'b0;
    chk({tv[i].name, "_done"},  32'(done), 32'(tv[i].exp_done));
    chk({tv[i].name, "_error"}, 32'(error), 32'(!tv[i].exp_done));
    chk({tv[i].name, "_hold"},  32'(cpu_hold), 32'(!tv[i].exp_done));
    chk({tv[i].name, "_busy"},  32'(busy), 32'd0);
    chk({tv[i].name, "_ready"}, 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk({tv[i].name, "_nwrites"}, 32'(wlog.size()), 32'(tv[i].nw));
    for (int k = 0; k < tv[i].nw && k < wlog.size(); k++) begin
      chk($sformatf("%s_addr%0d", tv[i].name, k), wlog[k].addr, 32'(k));
      chk($sformatf("%s_data%0d", tv[i].name, k), wlog[k].data, tv[i].w[k]);
    end
  endtask

  initial begin
    for (int i = 0; i < 7; i++) begin
      tv[i].w = '0;
      tv[i].garbage = 1'b0;
      tv[i].gap_max = 0;
      tv[i].bad_csum = 1'b0;
      tv[i].start_poke = 1'b0;
      tv[i].exp_done = 1'b1;
      tv[i].nw = 2;
      tv[i].w[0] = 32'h0000_0013;
      tv[i].w[1] = 32'hDEAD_BEEF;
    end
    tv[0].name = "nominal";
    tv[1].name = "resync";     tv[1].garbage = 1'b1;
    tv[2].name = "badcsum";    tv[2].bad_csum = 1'b1; tv[2].exp_done = 1'b0;
    tv[3].name = "rearm";
    tv[4].name = "n0";         tv[4].nw = 0;
    tv[5].name = "gaps";       tv[5].gap_max = 5; tv[5].start_poke = 1'b1;
    tv[6].name = "full";       tv[6].nw = MSZ;
    for (int k = 0; k < MSZ; k++)
      tv[6].w[k] = 32'h1000_0000 * (k + 1) + 32'h0102_0304 * k + 32'h55;

    #1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we",    32'(mem_we), 32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_hold",  32'(cpu_hold), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_load(i);

    // Oversize image: N = MEM_SIZE+1 must fail on the last length byte.
    wlog.delete();
    pulse_start();
    send_magic(0);
    send_byte(8'(MSZ + 1), 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    in_valid = 1'b0;
    chk("big_error", 32'(error), 32'd1);
    chk("big_done",  32'(done), 32'd0);
    chk("big_ready", 32'(in_ready), 32'd0);
    chk("big_hold",  32'(cpu_hold), 32'd1);
    repeat (3) @(negedge clk);
    chk("big_nwrites", 32'(wlog.size()), 32'd0);

    // Reset in the middle of the second word.
    wlog.delete();
    pulse_start();
    send_magic(0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    for (int b = 0; b < 4; b++) send_byte(tv[0].w[0][8*b +: 8], 0, 1'b0);
    for (int b = 0; b < 3; b++) send_byte(tv[0].w[1][8*b +: 8], 0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we",    32'(mem_we), 32'd0);
    chk("mid_rst_hold",  32'(cpu_hold), 32'd0);
    chk("mid_rst_busy",  32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_addr",  32'(mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_nwrites", 32'(wlog.size()), 32'd1);
    chk("mid_rst_idle",    32'(busy), 32'd0);
    run_load(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
